surfturf_wb_fanout: RTL

Parametrised, registered Wishbone fanout that replaces the combinational slot decode and ack/data mux in the SURF/TURF link wrapper.
It splits one upstream classic-cycle target into a core port plus NUM_SLOTS slot ports: slot 0 is the TURF, slots 1..NUM_SLOTS-1 are SURFs.
It adds the following, none of which the combinational version has:
- transaction FSM with registered strobes;
- per-slot enable mask;
- bus timeout with error termination;
- error response for unpopulated slots;
- saturating diagnostic counters.

---
 rtl/surfturf_wb_fanout_if.sv | 66 ++++++
 rtl/surfturf_wb_fanout.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/surfturf_wb_fanout_if.sv
// Bus bundle for the SURF/TURF Wishbone fanout: upstream target, core port, slot ports and diagnostics.
// slave = the fanout's view; master = the surrounding system (upstream initiator plus downstream targets).
interface surfturf_wb_fanout_if #(
  parameter int ADR_W      = 12,
  parameter int SLOT_ADR_W = 6,
  parameter int NUM_SLOTS  = 8,
  parameter int DAT_W      = 32,
  parameter int CNT_W      = 16
);
  localparam int SEL_W = DAT_W / 8;

  logic                        wb_cyc_i;
  logic                        wb_stb_i;
  logic                        wb_we_i;
  logic [ADR_W-1:0]            wb_adr_i;
  logic [DAT_W-1:0]            wb_dat_i;
  logic [SEL_W-1:0]            wb_sel_i;
  logic                        wb_ack_o;
  logic                        wb_err_o;
  logic                        wb_rty_o;
  logic [DAT_W-1:0]            wb_dat_o;

  logic                        core_cyc_o;
  logic                        core_stb_o;
  logic                        core_we_o;
  logic [ADR_W-2:0]            core_adr_o;
  logic [DAT_W-1:0]            core_dat_o;
  logic [SEL_W-1:0]            core_sel_o;
  logic                        core_ack_i;
  logic [DAT_W-1:0]            core_dat_i;

  logic [NUM_SLOTS-1:0]            slot_cyc_o;
  logic [NUM_SLOTS-1:0]            slot_stb_o;
  logic [NUM_SLOTS-1:0]            slot_we_o;
  logic [NUM_SLOTS*SLOT_ADR_W-1:0] slot_adr_o;
  logic [NUM_SLOTS*DAT_W-1:0]      slot_dat_o;
  logic [NUM_SLOTS*SEL_W-1:0]      slot_sel_o;
  logic [NUM_SLOTS-1:0]            slot_ack_i;
  logic [NUM_SLOTS*DAT_W-1:0]      slot_dat_i;
  logic [NUM_SLOTS-1:0]            slot_en_i;

  logic [CNT_W-1:0]            timeout_cnt_o;
  logic [CNT_W-1:0]            err_cnt_o;
  logic [7:0]                  last_err_slot_o;
  logic                        busy_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o,
    output core_cyc_o, core_stb_o, core_we_o, core_adr_o, core_dat_o, core_sel_o,
    input  core_ack_i, core_dat_i,
    output slot_cyc_o, slot_stb_o, slot_we_o, slot_adr_o, slot_dat_o, slot_sel_o,
    input  slot_ack_i, slot_dat_i, slot_en_i,
    output timeout_cnt_o, err_cnt_o, last_err_slot_o, busy_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o,
    input  core_cyc_o, core_stb_o, core_we_o, core_adr_o, core_dat_o, core_sel_o,
    output core_ack_i, core_dat_i,
    input  slot_cyc_o, slot_stb_o, slot_we_o, slot_adr_o, slot_dat_o, slot_sel_o,
    output slot_ack_i, slot_dat_i, slot_en_i,
    input  timeout_cnt_o, err_cnt_o, last_err_slot_o, busy_o
  );
endinterface

// File: rtl/surfturf_wb_fanout.sv
// Registered Wishbone fanout: upstream target -> core port + NUM_SLOTS slot ports; 3-cycle round trip with a zero-wait slave.
// Upstream is held off (no ack) while a target is busy; timeouts and bad targets end in a one-cycle err.
module surfturf_wb_fanout #(
  parameter int ADR_W      = 12,
  parameter int SLOT_ADR_W = 6,
  parameter int NUM_SLOTS  = 8,
  parameter int DAT_W      = 32,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 16
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n_i,
  surfturf_wb_fanout_if.slave bus
);
  localparam int SEL_W = DAT_W / 8;
  localparam int IDX_W = ADR_W - 1 - SLOT_ADR_W;
  localparam int TMR_W = 16;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;
  state_t state, state_nxt;

  logic [ADR_W-2:0] adr_q;
  logic [DAT_W-1:0] dat_q;
  logic [SEL_W-1:0] sel_q;
  logic             we_q;
  logic             tgt_core_q;
  logic [IDX_W-1:0] tgt_idx_q;
  logic [TMR_W-1:0] tmr_q;
  logic             resp_err_q;
  logic [DAT_W-1:0] resp_dat_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [7:0]       last_err_q;

  logic             req, dec_core, dec_ok;
  logic [IDX_W-1:0] dec_idx;
  logic             sel_ack;
  logic [DAT_W-1:0] sel_dat;
  logic             go_active, go_bad, done_ack, done_tmo;
  logic             active;
  logic [NUM_SLOTS-1:0] slot_hit;

  // Slot indices beyond NUM_SLOTS never match, so they fall out as bad targets.
  always_comb begin
    req      = bus.wb_cyc_i & bus.wb_stb_i;
    dec_core = bus.wb_adr_i[ADR_W-1];
    dec_idx  = bus.wb_adr_i[SLOT_ADR_W +: IDX_W];
    dec_ok   = dec_core;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (dec_idx == IDX_W'(i) && bus.slot_en_i[i]) dec_ok = 1'b1;
    end
  end

  always_comb begin
    sel_ack = tgt_core_q & bus.core_ack_i;
    sel_dat = bus.core_dat_i;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!tgt_core_q && tgt_idx_q == IDX_W'(i)) begin
        sel_ack = bus.slot_ack_i[i];
        sel_dat = bus.slot_dat_i[i*DAT_W +: DAT_W];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= IDLE;
    else             state <= state_nxt;
  end

  // Abort beats ack, and ack beats a timeout landing on the same edge.
  always_comb begin
    state_nxt = state;
    go_active = 1'b0;
    go_bad    = 1'b0;
    done_ack  = 1'b0;
    done_tmo  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (dec_ok) begin
            state_nxt = ACTIVE;
            go_active = 1'b1;
          end else begin
            state_nxt = RESP;
            go_bad    = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!bus.wb_cyc_i) begin
          state_nxt = IDLE;
        end else if (sel_ack) begin
          state_nxt = RESP;
          done_ack  = 1'b1;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          state_nxt = RESP;
          done_tmo  = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      tgt_core_q <= 1'b0;
      tgt_idx_q  <= '0;
      tmr_q      <= '0;
      resp_err_q <= 1'b0;
      resp_dat_q <= '0;
      tmo_cnt_q  <= '0;
      err_cnt_q  <= '0;
      last_err_q <= '0;
    end else begin
      if (go_active | go_bad) begin
        adr_q      <= bus.wb_adr_i[ADR_W-2:0];
        dat_q      <= bus.wb_dat_i;
        sel_q      <= bus.wb_sel_i;
        we_q       <= bus.wb_we_i;
        tgt_core_q <= dec_core;
        tgt_idx_q  <= dec_idx;
      end
      tmr_q <= (state == ACTIVE) ? tmr_q + 1'b1 : '0;
      if (go_bad | done_tmo) begin
        resp_err_q <= 1'b1;
        resp_dat_q <= '0;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        last_err_q <= go_bad ? 8'(dec_idx) : (tgt_core_q ? 8'hFF : 8'(tgt_idx_q));
      end else if (done_ack) begin
        resp_err_q <= 1'b0;
        resp_dat_q <= we_q ? '0 : sel_dat;
      end
      if (done_tmo && tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign active = (state == ACTIVE);

  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_hit[i] = active & ~tgt_core_q & (tgt_idx_q == IDX_W'(i));
    end
  end

  assign bus.wb_ack_o = (state == RESP) & ~resp_err_q;
  assign bus.wb_err_o = (state == RESP) &  resp_err_q;
  assign bus.wb_rty_o = 1'b0;
  assign bus.wb_dat_o = (state == RESP) ? resp_dat_q : '0;

  assign bus.core_cyc_o = active & tgt_core_q;
  assign bus.core_stb_o = active & tgt_core_q;
  assign bus.core_we_o  = we_q;
  assign bus.core_adr_o = adr_q;
  assign bus.core_dat_o = dat_q;
  assign bus.core_sel_o = sel_q;

  assign bus.slot_cyc_o = slot_hit;
  assign bus.slot_stb_o = slot_hit;
  assign bus.slot_we_o  = {NUM_SLOTS{we_q}};
  assign bus.slot_adr_o = {NUM_SLOTS{adr_q[SLOT_ADR_W-1:0]}};
  assign bus.slot_dat_o = {NUM_SLOTS{dat_q}};
  assign bus.slot_sel_o = {NUM_SLOTS{sel_q}};

  assign bus.timeout_cnt_o   = tmo_cnt_q;
  assign bus.err_cnt_o       = err_cnt_q;
  assign bus.last_err_slot_o = last_err_q;
  assign bus.busy_o          = (state != IDLE);
endmodule
